pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 13 +
 rtl/sat_counter.sv | 23 ++
 rtl/pipeline_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/flush controller.
package pipeline_ctrl_pkg;

    localparam int CNT_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        FLUSH_ALL = 2'd0,
        RUN       = 2'd1,
        FLUSH_BR  = 2'd2,
        FLUSH_LU  = 2'd3
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter
    import pipeline_ctrl_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: stage load enables, registered flush pulses
// and stall/flush performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 imem_req,
    input  logic                 imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    input  logic                 load_use,
    input  logic                 redirect,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 flush_ex_mem,
    output logic                 flush_mem_wb,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    state_e state;
    logic   mem_stall;
    logic   take_br;
    logic   take_lu;

    assign mem_stall = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp);

    // Hazards are only acted on from RUN and only when memory is not stalling.
    assign take_br = (state == RUN) && !mem_stall && redirect;
    assign take_lu = (state == RUN) && !mem_stall && !redirect && load_use;

    always_comb begin
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        case (state)
            RUN: begin
                if (!mem_stall) begin
                    load_ex_mem = 1'b1;
                    load_mem_wb = 1'b1;
                    if (!take_lu) begin
                        load_pc    = 1'b1;
                        load_if_id = 1'b1;
                        load_id_ex = 1'b1;
                    end
                end
            end
            FLUSH_BR, FLUSH_LU: begin
                // Front end stays frozen while its registers are being cleared.
                load_ex_mem = !mem_stall;
                load_mem_wb = !mem_stall;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FLUSH_ALL;
            flush_if_id  <= 1'b1;
            flush_id_ex  <= 1'b1;
            flush_ex_mem <= 1'b1;
            flush_mem_wb <= 1'b1;
        end else begin
            flush_if_id  <= 1'b0;
            flush_id_ex  <= 1'b0;
            flush_ex_mem <= 1'b0;
            flush_mem_wb <= 1'b0;
            case (state)
                FLUSH_ALL: state <= RUN;
                RUN: begin
                    if (take_br) begin
                        state       <= FLUSH_BR;
                        flush_if_id <= 1'b1;
                        flush_id_ex <= 1'b1;
                    end else if (take_lu) begin
                        state       <= FLUSH_LU;
                        flush_id_ex <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mem_stall && (state != FLUSH_ALL)),
        .count (stall_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (take_br),
        .count (flush_count)
    );

endmodule
